// File: rtl/benes_route_sequencer_pkg.sv
// Shared sizing, switch-configuration word type and sequencer states for the
// Benes route sequencer.
package benes_route_sequencer_pkg;

    localparam int unsigned PORT_NUM    = 32;
    localparam int unsigned SWITCH_NUM  = PORT_NUM / 2;
    localparam int unsigned STAGE_NUM   = 2 * $clog2(PORT_NUM) - 1;
    localparam int unsigned CFG_DEPTH   = 16;
    localparam int unsigned ADDR_W      = $clog2(CFG_DEPTH);
    localparam int unsigned LEN_W       = 8;
    localparam int unsigned NET_LATENCY = 8;
    localparam int unsigned OUT_LAT     = NET_LATENCY + 2;

    function automatic int unsigned cfg_w(input int unsigned port_num);
        return (2 * $clog2(port_num) - 1) * (port_num / 2);
    endfunction

    localparam int unsigned CFG_W = cfg_w(PORT_NUM);

    typedef logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] sw_cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_e;

endpackage

// File: rtl/benes_route_sequencer_cfg_table.sv
// Dual-word switch configuration table: one write port selecting the word,
// one registered read port returning both words of an entry.
module benes_cfg_table
    import benes_route_sequencer_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_WE,
    input  logic              I_SEL,
    input  logic [ADDR_W-1:0] I_WADDR,
    input  sw_cfg_t           I_WDATA,
    input  logic              I_RE,
    input  logic [ADDR_W-1:0] I_RADDR,
    output sw_cfg_t           O_MODULE_WORD,
    output sw_cfg_t           O_SLOT_WORD
);

    sw_cfg_t module_mem [CFG_DEPTH];
    sw_cfg_t slot_mem   [CFG_DEPTH];

    always_ff @(posedge CLK) begin
        if (I_WE) begin
            if (!I_SEL) begin
                module_mem[I_WADDR] <= I_WDATA;
            end else begin
                slot_mem[I_WADDR] <= I_WDATA;
            end
        end
    end

    // Read words only advance on a read, so the switch settings hold across stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            O_MODULE_WORD <= '0;
            O_SLOT_WORD   <= '0;
        end else if (I_RE) begin
            O_MODULE_WORD <= module_mem[I_RADDR];
            O_SLOT_WORD   <= slot_mem[I_RADDR];
        end
    end

endmodule

// File: rtl/benes_route_sequencer.sv
// Plays consecutive pre-computed switch configurations onto the dual Benes
// interconnect and tracks results through the fabric latency.
module benes_route_sequencer
    import benes_route_sequencer_pkg::*;
(
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  I_CFG_WE,
    input  logic                                  I_CFG_SEL,
    input  logic [ADDR_W-1:0]                     I_CFG_ADDR,
    input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]  I_CFG_DATA,
    input  logic                                  I_CMD_VALID,
    output logic                                  O_CMD_READY,
    input  logic [ADDR_W-1:0]                     I_CMD_BASE,
    input  logic [LEN_W-1:0]                      I_CMD_LEN,
    input  logic                                  I_STALL,
    output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]  O_MODULE_SELECT,
    output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]  O_SLOT_SELECT,
    output logic                                  O_ISSUE_VALID,
    output logic [ADDR_W-1:0]                     O_ISSUE_IDX,
    output logic                                  O_RESULT_VALID,
    output logic                                  O_BUSY,
    output logic                                  O_DONE
);

    seq_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   issue_idx_q;
    logic [LEN_W-1:0]    remain_q;
    logic                issue_valid_q;
    logic [OUT_LAT-1:0]  valid_sr_q;
    logic                cmd_accept;
    logic                issue_fire;
    logic                pipe_empty;

    benes_cfg_table u_cfg_table (
        .CLK           (CLK),
        .RST           (RST),
        .I_WE          (I_CFG_WE),
        .I_SEL         (I_CFG_SEL),
        .I_WADDR       (I_CFG_ADDR),
        .I_WDATA       (I_CFG_DATA),
        .I_RE          (issue_fire),
        .I_RADDR       (ptr_q),
        .O_MODULE_WORD (O_MODULE_SELECT),
        .O_SLOT_WORD   (O_SLOT_SELECT)
    );

    assign issue_fire = (state_q == ISSUE) && !I_STALL;
    // Empty once the last result is in the final tap: DONE follows that cycle.
    assign pipe_empty = !issue_valid_q && (valid_sr_q[OUT_LAT-2:0] == '0);

    always_comb begin
        state_d    = state_q;
        cmd_accept = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (I_CMD_VALID) begin
                    cmd_accept = 1'b1;
                    state_d    = (I_CMD_LEN == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue_fire && (remain_q == LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            remain_q      <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            valid_sr_q    <= '0;
        end else begin
            state_q       <= state_d;
            issue_valid_q <= issue_fire;
            valid_sr_q    <= {valid_sr_q[OUT_LAT-2:0], issue_valid_q};
            if (cmd_accept) begin
                ptr_q    <= I_CMD_BASE;
                remain_q <= I_CMD_LEN;
            end else if (issue_fire) begin
                ptr_q       <= ptr_q + 1'b1;
                remain_q    <= remain_q - 1'b1;
                issue_idx_q <= ptr_q;
            end
        end
    end

    assign O_CMD_READY    = (state_q == IDLE);
    assign O_BUSY         = (state_q != IDLE);
    assign O_DONE         = (state_q == DONE);
    assign O_ISSUE_VALID  = issue_valid_q;
    assign O_ISSUE_IDX    = issue_idx_q;
    assign O_RESULT_VALID = valid_sr_q[OUT_LAT-1];

endmodule

// File: tb/tb_benes_route_sequencer.sv
// Scoreboard bench for benes_route_sequencer: the driver predicts strobe
// cycles and issued words from the table contents; a monitor checks every cycle.
module tb_benes_route_sequencer;
    import benes_route_sequencer_pkg::*;

    typedef struct {
        int      cyc;
        int      idx;
        sw_cfg_t m;
        sw_cfg_t s;
    } iss_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              I_CFG_WE = 1'b0;
    logic              I_CFG_SEL = 1'b0;
    logic [ADDR_W-1:0] I_CFG_ADDR = '0;
    sw_cfg_t           I_CFG_DATA = '0;
    logic              I_CMD_VALID = 1'b0;
    logic              O_CMD_READY;
    logic [ADDR_W-1:0] I_CMD_BASE = '0;
    logic [LEN_W-1:0]  I_CMD_LEN = '0;
    logic              I_STALL = 1'b0;
    sw_cfg_t           O_MODULE_SELECT;
    sw_cfg_t           O_SLOT_SELECT;
    logic              O_ISSUE_VALID;
    logic [ADDR_W-1:0] O_ISSUE_IDX;
    logic              O_RESULT_VALID;
    logic              O_BUSY;
    logic              O_DONE;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      busy_lo = 1;
    int      busy_hi = 0;
    iss_t    iq[$];
    int      rq[$];
    int      dq[$];
    sw_cfg_t last_m = '0;
    sw_cfg_t last_s = '0;
    sw_cfg_t mod_m  [CFG_DEPTH];
    sw_cfg_t slot_m [CFG_DEPTH];

    benes_route_sequencer dut (
        .CLK             (CLK),
        .RST             (RST),
        .I_CFG_WE        (I_CFG_WE),
        .I_CFG_SEL       (I_CFG_SEL),
        .I_CFG_ADDR      (I_CFG_ADDR),
        .I_CFG_DATA      (I_CFG_DATA),
        .I_CMD_VALID     (I_CMD_VALID),
        .O_CMD_READY     (O_CMD_READY),
        .I_CMD_BASE      (I_CMD_BASE),
        .I_CMD_LEN       (I_CMD_LEN),
        .I_STALL         (I_STALL),
        .O_MODULE_SELECT (O_MODULE_SELECT),
        .O_SLOT_SELECT   (O_SLOT_SELECT),
        .O_ISSUE_VALID   (O_ISSUE_VALID),
        .O_ISSUE_IDX     (O_ISSUE_IDX),
        .O_RESULT_VALID  (O_RESULT_VALID),
        .O_BUSY          (O_BUSY),
        .O_DONE          (O_DONE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic sw_cfg_t rnd_cfg();
        logic [159:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return v[143:0];
    endfunction

    // Monitor: every cycle the strobes must equal what the scoreboard predicts.
    always @(negedge CLK) begin
        bit   ev;
        bit   eb;
        iss_t e;
        if (!RST) begin
            ev = (iq.size() > 0) && (iq[0].cyc == cyc);
            chk("issue_valid", 144'(O_ISSUE_VALID), 144'(ev));
            if (ev) begin
                e = iq.pop_front();
                chk("issue_idx", 144'(O_ISSUE_IDX), 144'(e.idx));
                chk("module_sel", O_MODULE_SELECT, e.m);
                chk("slot_sel", O_SLOT_SELECT, e.s);
                last_m = e.m;
                last_s = e.s;
            end else begin
                chk("module_hold", O_MODULE_SELECT, last_m);
                chk("slot_hold", O_SLOT_SELECT, last_s);
            end
            ev = (rq.size() > 0) && (rq[0] == cyc);
            chk("result_valid", 144'(O_RESULT_VALID), 144'(ev));
            if (ev) void'(rq.pop_front());
            ev = (dq.size() > 0) && (dq[0] == cyc);
            chk("done", 144'(O_DONE), 144'(ev));
            if (ev) void'(dq.pop_front());
            eb = (cyc >= busy_lo) && (cyc <= busy_hi);
            chk("busy", 144'(O_BUSY), 144'(eb));
            chk("cmd_ready", 144'(O_CMD_READY), 144'(!eb));
        end
    end

    task automatic write_entry(input int a, input sw_cfg_t m, input sw_cfg_t s);
        I_CFG_WE = 1'b1; I_CFG_SEL = 1'b0; I_CFG_ADDR = a[3:0]; I_CFG_DATA = m;
        mod_m[a] = m;
        @(posedge CLK); #1;
        I_CFG_SEL = 1'b1; I_CFG_DATA = s;
        slot_m[a] = s;
        @(posedge CLK); #1;
        I_CFG_WE = 1'b0;
    endtask

    // Accept at cycle t; each unstalled ISSUE cycle c yields an issue at c+1 and
    // a result OUT_LAT later; done follows the last result by one cycle.
    task automatic run_cmd(input int base, input int len, input logic [31:0] mask,
                           input int sp, input bit ovw, input int abort_at);
        int      t, j, k, last, done_c, idx;
        bit      st;
        sw_cfg_t nw;
        iss_t    e;
        t = cyc;
        I_CMD_VALID = 1'b1; I_CMD_BASE = base[3:0]; I_CMD_LEN = len[7:0];
        busy_lo = t + 1; busy_hi = 32'h7fffffff;
        @(posedge CLK); #1;
        I_CMD_VALID = 1'b0;
        j = 0; k = 0; last = t;
        while (k < len) begin
            if (abort_at != 0 && j == abort_at) begin
                RST = 1'b1;
                iq.delete(); rq.delete(); dq.delete();
                busy_hi = cyc; last_m = '0; last_s = '0;
                #1;
                chk("rst_issue_valid", 144'(O_ISSUE_VALID), 144'(0));
                chk("rst_result_valid", 144'(O_RESULT_VALID), 144'(0));
                chk("rst_done", 144'(O_DONE), 144'(0));
                chk("rst_busy", 144'(O_BUSY), 144'(0));
                chk("rst_cmd_ready", 144'(O_CMD_READY), 144'(1));
                @(posedge CLK); #1;
                RST = 1'b0; I_STALL = 1'b0;
                return;
            end
            st = (j < 32 && mask[j]) || ($urandom_range(99) < sp);
            I_STALL = st;
            if (!st) begin
                idx = (base + k) % CFG_DEPTH;
                e.cyc = cyc + 1; e.idx = idx; e.m = mod_m[idx]; e.s = slot_m[idx];
                iq.push_back(e);
                rq.push_back(cyc + 1 + OUT_LAT);
                last = cyc + 1;
                k++;
                if (ovw && j == 0) begin
                    nw = rnd_cfg();
                    I_CFG_WE = 1'b1; I_CFG_SEL = 1'b0; I_CFG_ADDR = idx[3:0]; I_CFG_DATA = nw;
                    mod_m[idx] = nw;
                end
            end
            j++;
            @(posedge CLK); #1;
            I_CFG_WE = 1'b0;
        end
        I_STALL = 1'($urandom_range(1));
        done_c = (len > 0) ? last + OUT_LAT + 1 : t + 1;
        dq.push_back(done_c);
        busy_hi = done_c;
        while (cyc <= done_c) begin
            @(posedge CLK); #1;
        end
        I_STALL = 1'b0;
    endtask

    initial begin
        logic [143:0] one;
        one = 144'h1;
        #2;
        chk("reset_cmd_ready", 144'(O_CMD_READY), 144'(1));
        chk("reset_busy", 144'(O_BUSY), 144'(0));
        chk("reset_issue_valid", 144'(O_ISSUE_VALID), 144'(0));
        chk("reset_result_valid", 144'(O_RESULT_VALID), 144'(0));
        chk("reset_done", 144'(O_DONE), 144'(0));
        chk("reset_issue_idx", 144'(O_ISSUE_IDX), 144'(0));
        chk("reset_module_sel", O_MODULE_SELECT, '0);
        chk("reset_slot_sel", O_SLOT_SELECT, '0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int i = 0; i < CFG_DEPTH; i++) write_entry(i, rnd_cfg(), rnd_cfg());
        for (int i = 0; i < 4; i++) write_entry(i, one << i, ~(one << i));

        run_cmd(0, 4, 32'h0, 0, 1'b0, 0);
        run_cmd(14, 5, 32'h0, 0, 1'b0, 0);
        run_cmd(0, 3, 32'h6, 0, 1'b0, 0);
        run_cmd(7, 0, 32'h0, 0, 1'b0, 0);
        run_cmd(0, 8, 32'h0, 0, 1'b0, 3);
        repeat (3) begin @(posedge CLK); #1; end
        run_cmd(4, 6, 32'h0, 0, 1'b0, 0);
        run_cmd(2, 1, 32'h0, 0, 1'b1, 0);
        run_cmd(2, 1, 32'h0, 0, 1'b0, 0);
        run_cmd(5, 20, 32'h0, 0, 1'b0, 0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(2) == 0) write_entry($urandom_range(CFG_DEPTH - 1), rnd_cfg(), rnd_cfg());
            repeat ($urandom_range(2)) begin @(posedge CLK); #1; end
            run_cmd($urandom_range(CFG_DEPTH - 1), $urandom_range(40), 32'h0,
                    $urandom_range(40), 1'($urandom_range(3) == 0), 0);
        end

        repeat (5) begin @(posedge CLK); #1; end
        chk("issue_queue_left", 144'(iq.size()), 144'(0));
        chk("result_queue_left", 144'(rq.size()), 144'(0));
        chk("done_queue_left", 144'(dq.size()), 144'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cycle %0d got running expected finished", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/benes_route_sequencer.md
Name: benes_route_sequencer

Overview:
- Controller for the dual Benes interconnect (RAM-to-module and module-to-RAM networks).
- Holds a table of pre-computed switch configurations, one module-select word and one slot-select word per entry.
- On a command, plays LEN consecutive entries onto the interconnect's select inputs, one per cycle, with optional stall.
- Produces issue strobes for the data sources and a latency-matched result-valid strobe. Pulses done when the last result has left the fabric.

Parameters:
- PORT_NUM, 32, network port count.
- SWITCH_NUM, PORT_NUM/2, switches per stage.
- STAGE_NUM, 2*$clog2(PORT_NUM)-1, switch stages; the config word is STAGE_NUM*SWITCH_NUM bits (CFG_W).
- CFG_DEPTH, 16, configuration table entries (power of two).
- LEN_W, 8, width of the command length field.
- NET_LATENCY, 8, cycles through one packed_network instance.
- OUT_LAT, NET_LATENCY+2, select-valid to result-valid delay (interconnect input register + network + output register).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- I_CFG_WE  in  1  table write enable.
- I_CFG_SEL  in  1  0 = module-select word, 1 = slot-select word.
- I_CFG_ADDR  in  $clog2(CFG_DEPTH)  table write address.
- I_CFG_DATA  in  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  config word.
- I_CMD_VALID  in  1  command request.
- O_CMD_READY  out  1  high only in IDLE.
- I_CMD_BASE  in  $clog2(CFG_DEPTH)  first table entry.
- I_CMD_LEN  in  LEN_W  number of beats.
- I_STALL  in  1  hold issue this cycle.
- O_MODULE_SELECT  out  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  to the interconnect's I_MODULE_SELECT.
- O_SLOT_SELECT  out  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  to the interconnect's I_SLOT_SELECT.
- O_ISSUE_VALID  out  1  selects valid; sources present data this cycle.
- O_ISSUE_IDX  out  $clog2(CFG_DEPTH)  table entry currently on the selects.
- O_RESULT_VALID  out  1  interconnect outputs valid this cycle.
- O_BUSY  out  1  state != IDLE.
- O_DONE  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset (RST high, asynchronous):
  - All outputs 0 except O_CMD_READY = 1.
  - State IDLE, counters 0, valid shift register cleared.
  - Table contents not reset; they are undefined until written.
- Table writes:
  - Accepted in any state.
  - A read of the same entry in the same cycle returns the old value (registered read, write-first not required).
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - O_CMD_READY = 1.
  - I_CMD_VALID with LEN > 0: latch BASE/LEN, set ptr = BASE, remain = LEN, go to ISSUE.
  - I_CMD_VALID with LEN = 0: accept, go directly to DONE; no issue and no result strobe.
- ISSUE, each cycle with I_STALL = 0:
  - Read table[ptr], both words.
  - Next cycle: drive O_MODULE_SELECT / O_SLOT_SELECT, with O_ISSUE_VALID = 1 and O_ISSUE_IDX = ptr.
  - ptr = (ptr + 1) mod CFG_DEPTH (wraps), remain decrements.
  - When remain reaches 0, go to DRAIN.
- ISSUE with I_STALL = 1:
  - ptr and remain are held.
  - The following cycle O_ISSUE_VALID = 0 and the selects hold their last value (no glitch on the switch settings).
- Result timing:
  - O_RESULT_VALID is O_ISSUE_VALID delayed by exactly OUT_LAT cycles through a shift register.
  - Stall bubbles propagate as gaps.
- DRAIN:
  - Wait until the shift register is empty and no issue is pending, then go to DONE.
  - For an unstalled command of LEN beats accepted at cycle t: O_ISSUE_VALID spans t+2..t+1+LEN, O_RESULT_VALID spans t+2+OUT_LAT..t+1+OUT_LAT+LEN, O_DONE is asserted at t+2+OUT_LAT+LEN.
- DONE: O_DONE = 1 for one cycle, then IDLE.
- O_CMD_READY is low in DONE, so a new command cannot be accepted in the same cycle as O_DONE.
- LEN greater than CFG_DEPTH is legal; the entry sequence wraps and repeats.
- Mid-operation reset: everything aborts immediately. O_ISSUE_VALID and O_RESULT_VALID drop asynchronously; no O_DONE pulse.
- I_STALL is ignored outside ISSUE.

Decomposition:
- Shared package (util_pack or a benes_pkg):
  - CFG_W localparam function.
  - typedef sw_cfg_t = logic [0:STAGE_NUM-1][0:SWITCH_NUM-1].
  - seq_state_e enum {IDLE, ISSUE, DRAIN, DONE}.
- One natural sub-module, benes_cfg_table: dual-word, CFG_DEPTH-entry RAM with one write port and one registered read port returning both words.
- FSM, counters and valid shift register stay in the top module.

Test Plan:
- Write entries 0..3 (module = 144'h1 << i, slot = ~module), then command BASE=0, LEN=4 at cycle t:
  - O_ISSUE_VALID at t+2..t+5 with IDX 0,1,2,3 and matching words.
  - O_RESULT_VALID at t+12..t+15.
  - O_DONE at t+16, then O_CMD_READY = 1.
- BASE=14, LEN=5, CFG_DEPTH=16 -> O_ISSUE_IDX sequence 14,15,0,1,2 (wrap-around).
- LEN=3 with I_STALL high for 2 cycles after the first issue:
  - O_ISSUE_VALID pattern 1,0,0,1,1; selects hold during the gap.
  - O_RESULT_VALID shows the same pattern shifted by 10; O_DONE is 2 cycles later than the unstalled case.
- LEN=0 -> O_DONE on the cycle after acceptance; no issue or result strobes; O_BUSY high for exactly 1 cycle.
- Assert RST for 1 cycle during ISSUE of LEN=8 -> all strobes 0 at once, no O_DONE, O_CMD_READY = 1. A new command afterwards runs normally.
- Overwrite entry 2 in the same cycle it is read -> old word is issued; the next command using entry 2 issues the new word.
